// File: rtl/calc_sequencer.sv
// calc_sequencer: debounced operand loading, ALU start/timeout and writeback sequencing.
module calc_sequencer #(
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       clear_n,
  input  logic       next,
  input  logic [2:0] MS,
  input  logic       chain,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       WE,
  output logic [1:0] waddr,
  output logic       wsel,
  output logic       alu_start,
  output logic [3:0] MS_out,
  output logic [1:0] LEDsel,
  output logic       Done_out,
  output logic       Err_out,
  output logic [3:0] state
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int EW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DB = DW'(DB_CYCLES);
  localparam logic [EW-1:0] TO_LAST = EW'(TIMEOUT - 1);
  typedef enum logic [3:0] {
    IDLE_A = 4'd0, LOAD_A = 4'd1, IDLE_B = 4'd2, LOAD_B = 4'd3, SEL_OP = 4'd4,
    EXEC = 4'd5, WB = 4'd6, DONE = 4'd7, CHAIN = 4'd8, ERROR = 4'd9
  } state_t;
  state_t st;
  logic s1, s2, armed, press;
  logic [DW-1:0] hi_cnt, lo_cnt;
  logic [EW-1:0] exec_cnt;
  logic [3:0] op_q;
  assign press = armed && hi_cnt == DB;
  assign state = st;
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      st <= IDLE_A;
      s1 <= 1'b0;
      s2 <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
      armed <= 1'b1;
      exec_cnt <= '0;
      op_q <= '0;
    end else begin
      s1 <= next;
      s2 <= s1;
      hi_cnt <= !s2 ? '0 : hi_cnt == DB ? DB : hi_cnt + 1'b1;
      lo_cnt <= s2 ? '0 : lo_cnt == DB ? DB : lo_cnt + 1'b1;
      armed <= press ? 1'b0 : lo_cnt == DB ? 1'b1 : armed;
      exec_cnt <= st == EXEC ? exec_cnt + 1'b1 : '0;
      case (st)
        IDLE_A: st <= press ? LOAD_A : IDLE_A;
        LOAD_A: st <= IDLE_B;
        IDLE_B: st <= press ? LOAD_B : IDLE_B;
        LOAD_B: st <= SEL_OP;
        SEL_OP: begin
          if (press) begin
            op_q <= {1'b0, MS};
            st <= EXEC;
          end
        end
        EXEC: st <= alu_done ? (alu_err ? ERROR : WB) : exec_cnt == TO_LAST ? ERROR : EXEC;
        WB: st <= DONE;
        DONE: st <= press ? (chain ? CHAIN : IDLE_A) : DONE;
        CHAIN: st <= IDLE_B;
        ERROR: st <= press ? IDLE_A : ERROR;
        default: st <= IDLE_A;
      endcase
    end
  end
  always_comb begin
    WE = 1'b0;
    waddr = 2'd0;
    wsel = 1'b0;
    alu_start = 1'b0;
    MS_out = 4'd0;
    LEDsel = 2'b00;
    Done_out = 1'b0;
    Err_out = 1'b0;
    case (st)
      LOAD_A: WE = 1'b1;
      LOAD_B: begin
        WE = 1'b1;
        waddr = 2'd1;
        LEDsel = 2'b01;
      end
      SEL_OP: begin
        LEDsel = 2'b01;
        MS_out = {1'b0, MS};
      end
      EXEC: begin
        MS_out = op_q;
        alu_start = exec_cnt == '0;
      end
      WB: begin
        WE = 1'b1;
        waddr = 2'd2;
        wsel = 1'b1;
        MS_out = op_q;
      end
      DONE: begin
        LEDsel = 2'b10;
        Done_out = 1'b1;
        MS_out = op_q;
      end
      CHAIN: begin
        WE = 1'b1;
        wsel = 1'b1;
        MS_out = op_q;
      end
      ERROR: begin
        LEDsel = 2'b11;
        Err_out = 1'b1;
        MS_out = op_q;
      end
      default: ;
    endcase
  end
endmodule
